// File: rtl/uart_hex_tx.sv
// uart_hex_tx: sends a captured value as ASCII hex text in 8N1 frames paced by a 16x baud tick.
// Define UART_HEX_CRLF_EN to append CR LF to every message.
module uart_hex_tx #(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_tick,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic                    busy,
  output logic                    done_tick,
  output logic                    tx
);
  localparam int BW = $clog2(DBIT + 1);
  localparam int IW = $clog2(NUM_DIGITS + 2);
`ifdef UART_HEX_CRLF_EN
  localparam int LAST = NUM_DIGITS + 1;
`else
  localparam int LAST = NUM_DIGITS - 1;
`endif
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [4:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] msg_q, msg_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic tx_q, tx_d, done_q, done_d;
  logic [3:0] nib;
  logic [7:0] char_b;
  logic tick_end;
  // Character 0 is the most significant nibble.
  always_comb begin
    nib = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx_q == IW'(NUM_DIGITS - 1 - i)) nib = msg_q[4*i +: 4];
  end
  assign char_b = idx_q == IW'(NUM_DIGITS) ? 8'h0D :
                  idx_q == IW'(NUM_DIGITS + 1) ? 8'h0A :
                  nib > 4'd9 ? 8'h37 + {4'h0, nib} : 8'h30 + {4'h0, nib};
  assign tick_end = s_tick && tick_q == (state_q == STOP ? 5'(SB_TICK - 1) : 5'd15);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      msg_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      msg_q   <= msg_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end
  // A start coinciding with done_tick is dropped, so done_q gates acceptance.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    msg_d   = msg_q;
    shift_d = shift_q;
    if (state_q == IDLE) begin
      if (start && !done_q) begin
        state_d = START;
        msg_d   = value;
        idx_d   = '0;
        tick_d  = '0;
      end
    end else if (s_tick) begin
      tick_d = tick_end ? 5'd0 : tick_q + 5'd1;
      if (tick_end)
        case (state_q)
          START: begin
            state_d = DATA;
            shift_d = DBIT'(char_b);
            bit_d   = '0;
          end
          DATA: begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
            if (bit_q == BW'(DBIT - 1)) state_d = STOP;
          end
          STOP: begin
            if (idx_q == IW'(LAST)) state_d = IDLE;
            else begin
              idx_d   = idx_q + 1'b1;
              state_d = START;
            end
          end
          default: state_d = IDLE;
        endcase
    end
  end
  always_comb begin
    tx_d   = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
    done_d = state_q == STOP && tick_end && idx_q == IW'(LAST);
  end
  assign busy      = state_q != IDLE;
  assign done_tick = done_q;
  assign tx        = tx_q;
endmodule

// File: tb/tb_uart_hex_tx.sv
// tb_uart_hex_tx: directed tests for uart_hex_tx with a line decoder on tx.
// Expectations follow UART_HEX_CRLF_EN when the bench is built with it.
module tb_uart_hex_tx;
  logic clk = 1'b0, rst = 1'b1, s_tick = 1'b0, start = 1'b0;
  logic [15:0] value = '0;
  logic busy, done_tick, tx;
  int checks = 0, errors = 0;
  int ticks_busy = 0, dones = 0, frame_err = 0;
  logic [7:0] rx_bytes[$];
  logic [7:0] exp[$];
  bit tick_en = 1'b1;
  logic [7:0] rb;
  bit rbad, abrt;
`ifdef UART_HEX_CRLF_EN
  localparam int NCH = 6;
`else
  localparam int NCH = 4;
`endif

  uart_hex_tx dut (
    .clk(clk), .rst(rst), .s_tick(s_tick), .start(start), .value(value),
    .busy(busy), .done_tick(done_tick), .tx(tx)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    s_tick = tick_en && !s_tick;
  end

  always @(posedge clk) begin
    if (s_tick && busy) ticks_busy <= ticks_busy + 1;
    if (done_tick) dones <= dones + 1;
  end

  task automatic skip(input int k);
    int n;
    n = 0;
    while (n < k && !abrt) begin
      @(negedge clk);
      if (rst === 1'b1) abrt = 1'b1;
      else if (s_tick === 1'b1) n++;
    end
  endtask

  // Line decoder: samples each bit mid-way by counting ticks from the start-bit fall.
  always begin
    @(negedge clk);
    if (rst === 1'b0 && tx === 1'b0) begin
      abrt = 1'b0;
      rbad = 1'b0;
      skip(8);
      if (tx !== 1'b0) rbad = 1'b1;
      for (int i = 0; i < 8; i++) begin
        skip(16);
        rb[i] = tx;
      end
      skip(16);
      if (tx !== 1'b1) rbad = 1'b1;
      if (!abrt) begin
        rx_bytes.push_back(rb);
        if (rbad) frame_err++;
      end
    end
  end

  task automatic add_exp(input logic [7:0] a, b, c, d);
    exp.push_back(a);
    exp.push_back(b);
    exp.push_back(c);
    exp.push_back(d);
`ifdef UART_HEX_CRLF_EN
    exp.push_back(8'h0D);
    exp.push_back(8'h0A);
`endif
  endtask

  task automatic pulse(input logic [15:0] v);
    @(negedge clk);
    value = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    value = 16'hDEAD;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      ok = done_tick === 1'b1;
    end
  endtask

  task automatic wait_rel(input int t0, input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      ok = ticks_busy - t0 >= n;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_tick); end
    value = 16'h1234;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_busy: got %b want 0", busy); end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_after_busy: got %b want 0", busy); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_after_tx: got %b want 1", tx); end
    checks++; if (rx_bytes.size() != 0) begin errors++; $display("FAIL reset_after_bytes: got %0d want 0", rx_bytes.size()); end
  endtask

  task automatic test_basic;
    int t0, d0, fe0;
    bit ok;
    logic [7:0] got;
    rx_bytes.delete(); exp.delete();
    add_exp(8'h31, 8'h41, 8'h32, 8'h46);
    d0 = dones; fe0 = frame_err;
    pulse(16'h1A2F);
    t0 = ticks_busy;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done: got timeout want done_tick"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    checks++; if (ticks_busy - t0 != NCH * 160) begin errors++; $display("FAIL basic_ticks: got %0d want %0d", ticks_busy - t0, NCH * 160); end
    repeat (40) @(negedge clk);
    checks++; if (dones - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", dones - d0); end
    checks++; if (rx_bytes.size() != exp.size()) begin errors++; $display("FAIL basic_count: got %0d want %0d", rx_bytes.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = i < rx_bytes.size() ? rx_bytes[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", i, got, exp[i]); end
    end
    checks++; if (frame_err != fe0) begin errors++; $display("FAIL basic_framing: got %0d want 0", frame_err - fe0); end
  endtask

  task automatic test_digits;
    int t0;
    bit ok;
    logic [7:0] got;
    rx_bytes.delete(); exp.delete();
    add_exp(8'h30, 8'h39, 8'h46, 8'h45);
    pulse(16'h09FE);
    t0 = ticks_busy;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL digits_done: got timeout want done_tick"); end
    checks++; if (ticks_busy - t0 != NCH * 160) begin errors++; $display("FAIL digits_ticks: got %0d want %0d", ticks_busy - t0, NCH * 160); end
    checks++; if (rx_bytes.size() != exp.size()) begin errors++; $display("FAIL digits_count: got %0d want %0d", rx_bytes.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = i < rx_bytes.size() ? rx_bytes[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL digits_byte%0d: got %h want %h", i, got, exp[i]); end
    end
    repeat (60) @(negedge clk);
    checks++; if (rx_bytes.size() != exp.size()) begin errors++; $display("FAIL digits_trailing: got %0d bytes want %0d", rx_bytes.size(), exp.size()); end
  endtask

  task automatic test_back_to_back;
    int t0;
    bit ok;
    logic [7:0] got;
    rx_bytes.delete(); exp.delete();
    add_exp(8'h31, 8'h41, 8'h32, 8'h46);
    add_exp(8'h42, 8'h37, 8'h43, 8'h35);
    pulse(16'h1A2F);
    t0 = ticks_busy;
    wait_rel(t0, 300, ok);
    pulse(16'hFFFF);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_mid: got %b want 1", busy); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done1: got timeout want done_tick"); end
    value = 16'h5555;
    start = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_cycle_start: got busy %b want 0", busy); end
    value = 16'hB7C5;
    @(negedge clk);
    start = 1'b0;
    value = 16'hDEAD;
    t0 = ticks_busy;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_next_cycle_start: got busy %b want 1", busy); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done2: got timeout want done_tick"); end
    checks++; if (ticks_busy - t0 != NCH * 160) begin errors++; $display("FAIL b2b_ticks: got %0d want %0d", ticks_busy - t0, NCH * 160); end
    checks++; if (rx_bytes.size() != exp.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", rx_bytes.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = i < rx_bytes.size() ? rx_bytes[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_reset_midframe;
    int t0;
    bit ok;
    logic [7:0] got;
    rx_bytes.delete(); exp.delete();
    add_exp(8'h30, 8'h30, 8'h30, 8'h30);
    pulse(16'h1A2F);
    t0 = ticks_busy;
    wait_rel(t0, 230, ok);
    checks++; if (!ok || tx !== 1'b0) begin errors++; $display("FAIL midrst_bit3: got tx %b want 0", tx); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL midrst_resume: got busy %b tx %b want 0 1", busy, tx); end
    rx_bytes.delete();
    pulse(16'h0000);
    t0 = ticks_busy;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_done: got timeout want done_tick"); end
    checks++; if (ticks_busy - t0 != NCH * 160) begin errors++; $display("FAIL midrst_ticks: got %0d want %0d", ticks_busy - t0, NCH * 160); end
    checks++; if (rx_bytes.size() != exp.size()) begin errors++; $display("FAIL midrst_count: got %0d want %0d", rx_bytes.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = i < rx_bytes.size() ? rx_bytes[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL midrst_byte%0d: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_stall;
    int t0, lows, dn;
    bit ok;
    logic [7:0] got;
    rx_bytes.delete(); exp.delete();
    add_exp(8'h30, 8'h39, 8'h46, 8'h45);
    pulse(16'h09FE);
    t0 = ticks_busy;
    wait_rel(t0, 150, ok);
    tick_en = 1'b0;
    lows = 0; dn = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (done_tick !== 1'b0) dn++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL stall_tx: got %0d low cycles want 0", lows); end
    checks++; if (dn != 0 || busy !== 1'b1) begin errors++; $display("FAIL stall_hold: got done %0d busy %b want 0 1", dn, busy); end
    tick_en = 1'b1;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_done: got timeout want done_tick"); end
    checks++; if (ticks_busy - t0 != NCH * 160) begin errors++; $display("FAIL stall_ticks: got %0d want %0d", ticks_busy - t0, NCH * 160); end
    checks++; if (rx_bytes.size() != exp.size()) begin errors++; $display("FAIL stall_count: got %0d want %0d", rx_bytes.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = i < rx_bytes.size() ? rx_bytes[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL stall_byte%0d: got %h want %h", i, got, exp[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_digits;
    test_back_to_back;
    test_reset_midframe;
    test_stall;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
